// File: rtl/score_pkg.sv
// Shared constants, types and helpers for the score digit renderer.
package score_pkg;

   localparam int SCORE_W   = 10;
   localparam int BCD_W     = 4;
   localparam int BCD_N     = 3;
   localparam int MAX_SCORE = 999;

   localparam int SPR_W    = 16;
   localparam int SPR_H    = 16;
   localparam int N_DIGITS = 3;
   localparam int BOX_X    = 560;
   localparam int BOX_Y    = 16;

   localparam logic [3:0] BG_INDEX_DEF = 4'h0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   function automatic logic [SCORE_W-1:0] sat_score(
      input logic [SCORE_W-1:0] s
   );
      return (s > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : s;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_N*BCD_W-1:0] dabble_adj(
      input logic [BCD_N*BCD_W-1:0] b
   );
      logic [BCD_N*BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < BCD_N; i++) begin
         if (b[i*BCD_W +: BCD_W] >= 4'd5)
            r[i*BCD_W +: BCD_W] = b[i*BCD_W +: BCD_W] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_digit_renderer_bin2bcd.sv
// Sequential binary-to-BCD converter with a one-deep pending load.
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic [SCORE_W-1:0]           score_i,
   input  logic                         load_i,
   output logic [BCD_N-1:0][BCD_W-1:0]  digits_o,
   output logic                         busy_o
);

   localparam int BCD_F = BCD_N * BCD_W;
   localparam int SR_W  = BCD_F + SCORE_W;

   conv_state_t                  state_q, state_d;
   logic [SR_W-1:0]              sr_q, sr_d;
   logic [SR_W-1:0]              sr_adj;
   logic [3:0]                   cnt_q, cnt_d;
   logic                         pend_q, pend_d;
   logic [SCORE_W-1:0]           pval_q, pval_d;
   logic [BCD_N-1:0][BCD_W-1:0]  disp_q, disp_d;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         pval_q  <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         pval_q  <= pval_d;
         disp_q  <= disp_d;
      end
   end

   assign sr_adj = {dabble_adj(sr_q[SR_W-1 -: BCD_F]), sr_q[SCORE_W-1:0]};

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      pval_d  = pval_q;
      disp_d  = disp_q;
      unique case (state_q)
         IDLE: begin
            if (load_i) begin
               sr_d    = {{BCD_F{1'b0}}, sat_score(score_i)};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = {sr_adj[SR_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(SCORE_W-1))
               state_d = DONE;
            if (load_i) begin
               pend_d = 1'b1;
               pval_d = sat_score(score_i);
            end
         end
         DONE: begin
            disp_d = sr_q[SR_W-1 -: BCD_F];
            // A load arriving in DONE is newest, so it beats the pending value.
            if (pend_q || load_i) begin
               sr_d    = {{BCD_F{1'b0}},
                          load_i ? sat_score(score_i) : pval_q};
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o   = (state_q != IDLE);
      digits_o = disp_q;
   end

endmodule

// File: rtl/score_digit_renderer.sv
// Score box raster stage: digit sprite addressing, zero blanking and hit flag.
module score_digit_renderer
   import score_pkg::*;
#(
   parameter int unsigned DIGIT_W    = SPR_W,
   parameter int unsigned DIGIT_H    = SPR_H,
   parameter int unsigned NUM_DIGITS = N_DIGITS,
   parameter int unsigned ORIGIN_X   = BOX_X,
   parameter int unsigned ORIGIN_Y   = BOX_Y,
   parameter logic [3:0]  BG_INDEX   = BG_INDEX_DEF
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [SCORE_W-1:0]  score,
   input  logic                score_load,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   output logic [11:0]         rom_addr,
   input  logic [3:0]          rom_q,
   output logic [3:0]          palette_index,
   output logic                score_hit,
   output logic                busy
);

   localparam int CW = $clog2(DIGIT_W);
   localparam int RW = $clog2(DIGIT_H);

   localparam logic [9:0] X0 = 10'(ORIGIN_X);
   localparam logic [9:0] X1 = 10'(ORIGIN_X + NUM_DIGITS * DIGIT_W);
   localparam logic [9:0] Y0 = 10'(ORIGIN_Y);
   localparam logic [9:0] Y1 = 10'(ORIGIN_Y + DIGIT_H);

   logic [BCD_N-1:0][BCD_W-1:0]  digits;
   logic [9:0]                   dx;
   logic [RW-1:0]                row;
   logic [9:0]                   slot;
   logic                         in_box;
   logic [BCD_W-1:0]             dig;
   logic                         vis;
   logic [11:0]                  rom_addr_d, rom_addr_q;
   logic                         hit1_d, hit1_q, hit2_q;

   bin2bcd_seq u_conv (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .score_i  (score),
      .load_i   (score_load),
      .digits_o (digits),
      .busy_o   (busy)
   );

   assign dx   = DrawX - X0;
   assign row  = RW'(DrawY - Y0);
   assign slot = dx >> CW;

   // Lower bounds compared on raw coordinates so left-of-box never wraps.
   assign in_box = (DrawX >= X0) && (DrawX < X1)
                && (DrawY >= Y0) && (DrawY < Y1);

   always_comb begin
      dig = digits[0];
      vis = 1'b1;
      unique case (1'b1)
         (slot == 10'd0): begin
            dig = digits[2];
            vis = (digits[2] != '0);
         end
         (slot == 10'd1): begin
            dig = digits[1];
            vis = (digits[2] != '0) || (digits[1] != '0);
         end
         default: ;
      endcase
   end

   assign rom_addr_d = 12'({dig, row, dx[CW-1:0]});
   assign hit1_d     = in_box && vis;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         rom_addr_q <= '0;
         hit1_q     <= 1'b0;
         hit2_q     <= 1'b0;
      end else begin
         if (in_box)
            rom_addr_q <= rom_addr_d;
         hit1_q <= hit1_d;
         hit2_q <= hit1_q;
      end
   end

   assign rom_addr      = rom_addr_q;
   assign score_hit     = hit2_q;
   assign palette_index = hit2_q ? rom_q : BG_INDEX;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench for score_digit_renderer with a behavioural pixel model.
module tb_score_digit_renderer;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [9:0]  score;
   logic        score_load;
   logic [9:0]  DrawX, DrawY;
   logic [11:0] rom_addr;
   logic [3:0]  rom_q;
   logic [3:0]  palette_index;
   logic        score_hit;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int shown  = 0;
   int addr_m = 0;
   bit rom_const = 1'b0;
   int px[$];
   int py[$];

   always #5 Clk = ~Clk;

   score_digit_renderer dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .score         (score),
      .score_load    (score_load),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .rom_addr      (rom_addr),
      .rom_q         (rom_q),
      .palette_index (palette_index),
      .score_hit     (score_hit),
      .busy          (busy)
   );

   function automatic logic [3:0] rom_f(input logic [11:0] a);
      return rom_const ? 4'hA : (a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5);
   endfunction

   always @(posedge Clk) rom_q <= rom_f(rom_addr);

   function automatic bit m_inbox(input int x, input int y);
      return (x >= 560) && (x < 608) && (y >= 16) && (y < 32);
   endfunction

   function automatic bit m_hit(input int x, input int y, input int v);
      int k;
      if (!m_inbox(x, y)) return 1'b0;
      k = (x - 560) / 16;
      if (k == 0) return v >= 100;
      if (k == 1) return v >= 10;
      return 1'b1;
   endfunction

   function automatic int m_addr(input int x, input int y, input int v);
      int k;
      int d;
      k = (x - 560) / 16;
      d = (k == 0) ? v / 100 : (k == 1) ? (v / 10) % 10 : v % 10;
      return d * 256 + (y - 16) * 16 + (x - 560) % 16;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic do_load(input int s);
      score      = 10'(s);
      score_load = 1'b1;
      step();
      score_load = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n;
      n = 0;
      while (busy && n < maxc) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy timeout got %b want 0", tag, busy);
      end
   endtask

   // Streams the queued pixels and checks each against the display model.
   task automatic run_pix(input string tag);
      int n;
      bit eh[$];
      int ea[$];
      logic [3:0] ep;
      n = px.size();
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            DrawX = 10'(px[i]);
            DrawY = 10'(py[i]);
            if (m_inbox(px[i], py[i])) addr_m = m_addr(px[i], py[i], shown);
            eh.push_back(m_hit(px[i], py[i], shown));
            ea.push_back(addr_m);
         end else begin
            DrawX = 10'd0;
            DrawY = 10'd0;
         end
         step();
         if (i < n) begin
            checks++;
            if (rom_addr !== 12'(ea[i])) begin
               errors++;
               $display("FAIL %s rom_addr x=%0d y=%0d got %0d want %0d",
                        tag, px[i], py[i], rom_addr, ea[i]);
            end
         end
         if (i > 0) begin
            ep = eh[i-1] ? rom_f(12'(ea[i-1])) : 4'h0;
            checks++;
            if (score_hit !== eh[i-1] || palette_index !== ep) begin
               errors++;
               $display("FAIL %s pixel x=%0d y=%0d hit %b pal %h want %b %h",
                        tag, px[i-1], py[i-1], score_hit, palette_index,
                        eh[i-1], ep);
            end
         end
      end
      px.delete();
      py.delete();
   endtask

   task automatic rand_pix(input int n);
      for (int i = 0; i < n; i++) begin
         px.push_back(int'($urandom_range(550, 615)));
         py.push_back(int'($urandom_range(12, 35)));
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      step();
      Reset_n = 1'b1;
      shown  = 0;
      addr_m = 0;
      checks++;
      if (busy !== 1'b0 || score_hit !== 1'b0 ||
          palette_index !== 4'h0 || rom_addr !== 12'd0) begin
         errors++;
         $display("FAIL reset busy=%b hit=%b pal=%h addr=%0d want 0 0 0 0",
                  busy, score_hit, palette_index, rom_addr);
      end
      px = '{592, 560, 600, 575, 559};
      py = '{16, 16, 31, 20, 16};
      run_pix("reset_px");
   endtask

   task automatic test_convert();
      do_load(437);
      for (int j = 1; j <= 12; j++) begin
         checks++;
         if (busy !== (j <= 11)) begin
            errors++;
            $display("FAIL conv_busy cycle %0d got %b want %b", j, busy, j <= 11);
         end
         if (j < 12) step();
      end
      shown = 437;
      px = '{577, 560, 600, 591};
      py = '{18, 16, 25, 31};
      rand_pix(8);
      run_pix("conv437");
   endtask

   task automatic test_random();
      int vals[$];
      int s;
      vals = '{1023, 5, 0, 99, 100};
      for (int i = 0; i < 4; i++) vals.push_back(int'($urandom_range(0, 1023)));
      foreach (vals[i]) begin
         s = vals[i];
         do_load(s);
         wait_idle("rand_idle", 20);
         shown = (s > 999) ? 999 : s;
         px = '{560, 576, 592};
         py = '{16, 16, 16};
         rand_pix(10);
         run_pix("rand");
      end
   endtask

   task automatic test_pending(input int first, input int second, input int off);
      int c0;
      do_load(first);
      c0 = cyc;
      for (int j = 1; j <= 11; j++) begin
         if (j - 1 == off) begin
            score      = 10'(second);
            score_load = 1'b1;
         end
         step();
         score_load = 1'b0;
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_busy off=%0d cycle %0d got %b want 1", off, j, busy);
         end
      end
      shown = first;
      px = '{560, 576, 592};
      py = '{16, 17, 18};
      run_pix("pend_first");
      while (busy && (cyc - c0) < 40) step();
      checks++;
      if ((cyc - c0) != 22 || busy !== 1'b0) begin
         errors++;
         $display("FAIL pend_done off=%0d cycles %0d busy %b want 22 0",
                  off, cyc - c0, busy);
      end
      shown = (second > 999) ? 999 : second;
      px = '{560, 576, 592};
      py = '{16, 16, 16};
      rand_pix(6);
      run_pix("pend_second");
   endtask

   task automatic test_scan();
      do_load(888);
      wait_idle("scan_idle", 20);
      shown = 888;
      rom_const = 1'b1;
      for (int x = 558; x <= 609; x++) begin
         px.push_back(x);
         py.push_back(20);
      end
      run_pix("scan_y20");
      for (int x = 558; x <= 609; x++) begin
         px.push_back(x);
         py.push_back(32);
      end
      run_pix("scan_y32");
      rom_const = 1'b0;
   endtask

   task automatic test_reset_mid();
      int bad;
      do_load(250);
      step();
      step();
      do_load(777);
      step();
      step();
      Reset_n = 1'b0;
      step();
      Reset_n = 1'b1;
      shown  = 0;
      addr_m = 0;
      checks++;
      if (busy !== 1'b0 || rom_addr !== 12'd0 || score_hit !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid busy=%b addr=%0d hit=%b want 0 0 0",
                  busy, rom_addr, score_hit);
      end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_mid_idle busy cycles got %0d want 0", bad);
      end
      px = '{560, 576, 592, 607};
      py = '{16, 16, 16, 31};
      run_pix("rst_mid_px");
   endtask

   initial begin
      Reset_n    = 1'b1;
      score      = 10'd0;
      score_load = 1'b0;
      DrawX      = 10'd0;
      DrawY      = 10'd0;
      test_reset();
      test_convert();
      test_random();
      test_pending(12, 980, 3);
      test_pending(50, 700, 10);
      test_scan();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
